// File: rtl/chf_pll_pkg.sv
// -----------------------------------------------------------------------------
// chf_pll_pkg
// Shared definitions for the PLL reconfiguration sequencer: FSM state encoding,
// pll_cfg management-port register addresses, the NTSC/PAL register values and
// a lookup of the fixed six-entry write program.
// -----------------------------------------------------------------------------
package chf_pll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        DONE = 2'd2,
        LOCK = 2'd3
    } state_t;

    // pll_cfg register map
    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C0    = 6'd5;
    localparam logic [5:0] ADDR_MFRAC = 6'd7;

    // Register values; N and M are common to both standards
    localparam logic [31:0] DATA_MODE  = 32'h0000_0000;  // waitrequest mode
    localparam logic [31:0] DATA_START = 32'h0000_0000;
    localparam logic [31:0] DATA_N     = 32'h0001_0000;
    localparam logic [31:0] DATA_M     = 32'h0000_0404;
    localparam logic [31:0] C0_NTSC    = 32'h0000_0505;
    localparam logic [31:0] C0_PAL     = 32'h0002_0504;
    localparam logic [31:0] MFRAC_NTSC = 32'h9745_BF27;  // 42.95454 MHz
    localparam logic [31:0] MFRAC_PAL  = 32'hA3D7_09E8;  // 48 MHz

    localparam logic [2:0] LAST_IDX = 3'd5;

    // Returns {address, data} for program step idx; tgt=1 selects PAL.
    function automatic logic [37:0] prog_entry(input logic [2:0] idx, input logic tgt);
        logic [37:0] e;
        case (idx)
            3'd0:    e = {ADDR_MODE, DATA_MODE};
            3'd1:    e = {ADDR_N, DATA_N};
            3'd2:    e = {ADDR_M, DATA_M};
            3'd3:    e = {ADDR_C0, (tgt ? C0_PAL : C0_NTSC)};
            3'd4:    e = {ADDR_MFRAC, (tgt ? MFRAC_PAL : MFRAC_NTSC)};
            default: e = {ADDR_START, DATA_START};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/chf_sync_debounce.sv
// -----------------------------------------------------------------------------
// chf_sync_debounce
// Two-flop synchroniser with an optional stable-count compare.
//   STABLE_CYCLES > 0 : counts consecutive cycles the synchronised level differs
//                       from ref_i; trig_o pulses on the STABLE_CYCLES-th such
//                       cycle. hold_i forces the count to 0 and suppresses trig_o.
//   STABLE_CYCLES = 0 : plain synchroniser, trig_o tied low.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   async_i        asynchronous input level
//   ref_i          level the synchronised input is compared against
//   hold_i         freeze/clear the stable counter
//   sync_o         synchronised level (reset value INIT)
//   trig_o         stable-difference trigger (one cycle)
// -----------------------------------------------------------------------------
module chf_sync_debounce #(
    parameter bit INIT          = 1'b0,
    parameter int STABLE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    input  logic ref_i,
    input  logic hold_i,
    output logic sync_o,
    output logic trig_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

    generate
        if (STABLE_CYCLES > 0) begin : g_deb
            localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          differ;

            assign differ = (sync_q != ref_i);
            assign trig_o = !hold_i && differ && (cnt_q == CW'(STABLE_CYCLES - 1));

            // Any equality, hold or trigger restarts the run from zero.
            always_comb begin
                cnt_d = cnt_q + CW'(1);
                if (hold_i || !differ || trig_o) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_plain
            logic unused_ctl;
            assign unused_ctl = ^{ref_i, hold_i};
            assign trig_o     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/chf_pll_reconf.sv
// -----------------------------------------------------------------------------
// chf_pll_reconf
// Reprograms the system PLL through the pll_cfg Avalon-MM management port when
// the NTSC/PAL selection changes (NTSC 42.95454 MHz, PAL 48 MHz). The request is
// synchronised and debounced, a fixed six-write program is issued, and the core
// is held in reset (tv_reset) for the whole sequence.
//
// Optional build macro: CHF_PLL_LOCKWAIT_EN
//   When defined, the sequencer waits in LOCK after the program for pll_locked
//   to fall and rise again (or LOCK_TIMEOUT cycles) before releasing tv_reset.
//   When undefined, DONE returns straight to IDLE and pll_locked is unused.
//
// Ports:
//   clk               management clock (CLK_50M)
//   reset_n           asynchronous active-low reset
//   pal               requested standard (asynchronous)
//   pll_locked        PLL lock indicator (asynchronous)
//   mgmt_waitrequest  Avalon-MM waitrequest from pll_cfg
//   mgmt_write        Avalon-MM write strobe
//   mgmt_address      register address
//   mgmt_writedata    register data
//   tv_reset          core reset request, high while reconfiguring
//   busy              high in any state other than IDLE
//   cur_pal           standard currently programmed
// -----------------------------------------------------------------------------
module chf_pll_reconf
    import chf_pll_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter bit INIT_PAL        = 1'b0,
    parameter int LOCK_TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pal,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        tv_reset,
    output logic        busy,
    output logic        cur_pal
);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       tgt_q, tgt_d;
    logic       cur_pal_q, cur_pal_d;

    logic       pal_s;
    logic       pal_trig;
    logic       pll_locked_s;
    logic       lock_trig_unused;

    chf_sync_debounce #(
        .INIT          (INIT_PAL),
        .STABLE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pal_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (pal),
        .ref_i   (cur_pal_q),
        .hold_i  (busy),
        .sync_o  (pal_s),
        .trig_o  (pal_trig)
    );

    chf_sync_debounce #(
        .INIT          (1'b0),
        .STABLE_CYCLES (0)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (pll_locked),
        .ref_i   (1'b0),
        .hold_i  (1'b1),
        .sync_o  (pll_locked_s),
        .trig_o  (lock_trig_unused)
    );

`ifdef CHF_PLL_LOCKWAIT_EN
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          seen_low_q, seen_low_d;
`else
    localparam int unused_lock_timeout = LOCK_TIMEOUT;
    logic unused_lock;
    assign unused_lock = pll_locked_s;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tgt_d          = tgt_q;
        cur_pal_d      = cur_pal_q;
`ifdef CHF_PLL_LOCKWAIT_EN
        lock_cnt_d     = lock_cnt_q;
        seen_low_d     = seen_low_q;
`endif
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        busy           = (state_q != IDLE);
        tv_reset       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (pal_trig) begin
                    tgt_d   = pal_s;
                    idx_d   = 3'd0;
                    state_d = WR;
                end
            end
            WR: begin
                // Address/data come only from the latched target, so they stay
                // stable across waitrequest stalls regardless of live pal.
                mgmt_write                     = 1'b1;
                {mgmt_address, mgmt_writedata} = prog_entry(idx_q, tgt_q);
                if (!mgmt_waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                cur_pal_d = tgt_q;
`ifdef CHF_PLL_LOCKWAIT_EN
                lock_cnt_d = '0;
                seen_low_d = 1'b0;
                state_d    = LOCK;
`else
                state_d    = IDLE;
`endif
            end
            LOCK: begin
`ifdef CHF_PLL_LOCKWAIT_EN
                // A stale 'locked' from before the retune must not end the wait:
                // require a low sample first.
                if (!pll_locked_s) begin
                    seen_low_d = 1'b1;
                end
                if ((pll_locked_s && seen_low_q) || (lock_cnt_q == LW'(LOCK_TIMEOUT))) begin
                    state_d = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            tgt_q      <= INIT_PAL;
            cur_pal_q  <= INIT_PAL;
`ifdef CHF_PLL_LOCKWAIT_EN
            lock_cnt_q <= '0;
            seen_low_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tgt_q      <= tgt_d;
            cur_pal_q  <= cur_pal_d;
`ifdef CHF_PLL_LOCKWAIT_EN
            lock_cnt_q <= lock_cnt_d;
            seen_low_q <= seen_low_d;
`endif
        end
    end

    assign cur_pal = cur_pal_q;

endmodule

// File: tb/tb_chf_pll_reconf.sv
// -----------------------------------------------------------------------------
// tb_chf_pll_reconf
// Self-checking bench for chf_pll_reconf. A negedge monitor records every
// accepted management write, tv_reset/busy cycle counts and waitrequest stall
// behaviour; scenarios compare those against the register program expected for
// the requested standard.
// -----------------------------------------------------------------------------
module tb_chf_pll_reconf;

    localparam int DEB = 16;
    localparam int LT  = 64;
`ifdef CHF_PLL_LOCKWAIT_EN
    localparam int LOCK_EXTRA = LT + 1;
`else
    localparam int LOCK_EXTRA = 0;
`endif
    localparam int IDLE_LIMIT = 2000 + LOCK_EXTRA;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pal;
    logic        pll_locked = 1'b1;
    logic        mgmt_waitrequest = 1'b0;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        tv_reset;
    logic        busy;
    logic        cur_pal;

    int n_chk  = 0;
    int n_pass = 0;

    // 0: waitrequest low, 1: random, 2: three stall cycles per write
    int wr_mode = 0;

    logic [37:0] wr_q[$];
    int tv_cnt    = 0;
    int busy_cnt  = 0;
    int stall_cnt = 0;
    int unstable  = 0;

    chf_pll_reconf #(
        .DEBOUNCE_CYCLES (DEB),
        .INIT_PAL        (1'b0),
        .LOCK_TIMEOUT    (LT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pal              (pal),
        .pll_locked       (pll_locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .tv_reset         (tv_reset),
        .busy             (busy),
        .cur_pal          (cur_pal)
    );

    always #5 clk = ~clk;

    // Waitrequest driver, updated just after each rising edge.
    int stall_run = 0;
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            1: mgmt_waitrequest = 1'($urandom % 2);
            2: begin
                if (mgmt_write && stall_run < 3) begin
                    mgmt_waitrequest = 1'b1;
                    stall_run++;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall_run = 0;
                end
            end
            default: mgmt_waitrequest = 1'b0;
        endcase
    end

    // Monitor: the values seen at a negedge are what the next rising edge takes.
    logic        prev_stall = 1'b0;
    logic [37:0] prev_ad    = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall && !(mgmt_write && {mgmt_address, mgmt_writedata} == prev_ad))
                unstable++;
            if (mgmt_write && !mgmt_waitrequest) wr_q.push_back({mgmt_address, mgmt_writedata});
            if (mgmt_write && mgmt_waitrequest) stall_cnt++;
            if (tv_reset) tv_cnt++;
            if (busy) busy_cnt++;
            prev_stall = mgmt_write && mgmt_waitrequest;
            prev_ad    = {mgmt_address, mgmt_writedata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register program for one reconfiguration, straight from the register table.
    function automatic logic [37:0] exp_entry(input logic tgt, input int i);
        case (i)
            0: return {6'd0, 32'h0000_0000};
            1: return {6'd3, 32'h0001_0000};
            2: return {6'd4, 32'h0000_0404};
            3: return tgt ? {6'd5, 32'h0002_0504} : {6'd5, 32'h0000_0505};
            4: return tgt ? {6'd7, 32'hA3D7_09E8} : {6'd7, 32'h9745_BF27};
            default: return {6'd2, 32'h0000_0000};
        endcase
    endfunction

    task automatic wait_busy(input int limit, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (!busy) begin
            if (cyc >= limit) begin
                to = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic wait_idle(input int limit, output bit to);
        int cyc = 0;
        to = 1'b0;
        while (busy) begin
            if (cyc >= limit) begin
                to = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic wait_write_addr(input logic [5:0] a, input int limit, output bit to);
        int cyc = 0;
        to = 1'b0;
        while (!(mgmt_write && mgmt_address == a)) begin
            if (cyc >= limit) begin
                to = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic check_prog(input string tag, input logic tgt, input int base);
        for (int i = 0; i < 6; i++) begin
            if (base + i < wr_q.size())
                chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[base + i]), 64'(exp_entry(tgt, i)));
        end
    endtask

    // One complete reconfiguration from an idle, settled state.
    task automatic run_seq(input logic tgt, input int mode, input string tag);
        int lat;
        bit to;
        int wb, tb0, sb, ub;
        wr_mode = mode;
        wb  = wr_q.size();
        tb0 = tv_cnt;
        sb  = stall_cnt;
        ub  = unstable;
        pal = tgt;
        wait_busy(100, lat, to);
        chk({tag, "_start_timeout"}, 64'(to), 64'd0);
        chk({tag, "_latency"}, 64'(lat), 64'(2 + DEB));
        wait_idle(IDLE_LIMIT, to);
        chk({tag, "_done_timeout"}, 64'(to), 64'd0);
        tick();
        chk({tag, "_nwrites"}, 64'(wr_q.size() - wb), 64'd6);
        check_prog(tag, tgt, wb);
        chk({tag, "_tv_cycles"}, 64'(tv_cnt - tb0), 64'(7 + (stall_cnt - sb) + LOCK_EXTRA));
        chk({tag, "_cur_pal"}, 64'(cur_pal), 64'(tgt));
        chk({tag, "_stable"}, 64'(unstable - ub), 64'd0);
        wr_mode = 0;
    endtask

    initial begin
        int  wb, bb, len;
        bit  to;
        int  lat;
        logic model_pal;

        reset_n = 1'b0;
        pal     = 1'b0;
        repeat (3) tick();
        chk("rst_write", 64'(mgmt_write), 64'd0);
        chk("rst_addr", 64'(mgmt_address), 64'd0);
        chk("rst_data", 64'(mgmt_writedata), 64'd0);
        chk("rst_tv_reset", 64'(tv_reset), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_pal", 64'(cur_pal), 64'd0);

        // Quiet idle: nothing may happen while pal matches the power-up standard.
        reset_n = 1'b1;
        wb = wr_q.size();
        bb = busy_cnt;
        repeat (10000) tick();
        chk("idle_writes", 64'(wr_q.size() - wb), 64'd0);
        chk("idle_busy", 64'(busy_cnt - bb), 64'd0);

        run_seq(1'b1, 0, "ntsc2pal");
        run_seq(1'b0, 2, "pal2ntsc");

        // Short glitches never survive the debounce.
        for (int g = 0; g < 5; g++) begin
            wb  = wr_q.size();
            bb  = busy_cnt;
            len = $urandom_range(1, DEB - 1);
            pal = 1'b1;
            repeat (len) tick();
            pal = 1'b0;
            repeat (30) tick();
            chk($sformatf("glitch%0d_len%0d_busy", g, len), 64'(busy_cnt - bb), 64'd0);
            chk($sformatf("glitch%0d_writes", g), 64'(wr_q.size() - wb), 64'd0);
        end
        chk("glitch_cur_pal", 64'(cur_pal), 64'd0);

        // Request reverts mid-program: the running program completes with its
        // latched target, then a second full program follows.
        wb = wr_q.size();
        pal = 1'b1;
        wait_write_addr(6'd4, 200, to);
        chk("toggle_reach_idx2", 64'(to), 64'd0);
        pal = 1'b0;
        wait_idle(IDLE_LIMIT, to);
        chk("toggle_first_done", 64'(to), 64'd0);
        wait_busy(200, lat, to);
        chk("toggle_second_start", 64'(to), 64'd0);
        wait_idle(IDLE_LIMIT, to);
        chk("toggle_second_done", 64'(to), 64'd0);
        tick();
        chk("toggle_nwrites", 64'(wr_q.size() - wb), 64'd12);
        check_prog("toggle_a", 1'b1, wb);
        check_prog("toggle_b", 1'b0, wb + 6);
        chk("toggle_cur_pal", 64'(cur_pal), 64'(pal));

        // Reset in the middle of the C0 write.
        wr_mode = 2;
        pal = 1'b1;
        wait_write_addr(6'd5, 200, to);
        chk("rstmid_reach_idx3", 64'(to), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_write", 64'(mgmt_write), 64'd0);
        chk("rstmid_tv_reset", 64'(tv_reset), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_cur_pal", 64'(cur_pal), 64'd0);
        wr_mode = 0;
        pal = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        run_seq(1'b1, 0, "after_rst");

        // Randomised back-and-forth with random waitrequest.
        model_pal = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 20)) tick();
            model_pal = ~model_pal;
            run_seq(model_pal, 1, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
